// File: rtl/openmips_pkg.sv
// Shared pipeline constants and types for the openmips core.
package openmips_pkg;

  localparam logic        RstEnable    = 1'b0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic stall_wb;
  } stall_t;

endpackage

// File: rtl/ex_mem_if.sv
// EX-side inputs and MEM-side outputs of the EX/MEM pipeline register.
interface ex_mem_if #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int CNT_W = 2
);
  logic [AW-1:0]    ex_waddr;
  logic             ex_wreg;
  logic [DW-1:0]    ex_wdata;
  logic             ex_whilo;
  logic [DW-1:0]    ex_hi;
  logic [DW-1:0]    ex_lo;
  logic [2*DW-1:0]  hilo_temp_i;
  logic [CNT_W-1:0] cnt_i;

  logic [AW-1:0]    mem_waddr;
  logic             mem_wreg;
  logic [DW-1:0]    mem_wdata;
  logic             mem_whilo;
  logic [DW-1:0]    mem_hi;
  logic [DW-1:0]    mem_lo;
  logic [2*DW-1:0]  hilo_temp_o;
  logic [CNT_W-1:0] cnt_o;

  modport master (
    output ex_waddr, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_temp_i, cnt_i,
    input  mem_waddr, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_temp_o, cnt_o
  );

  modport slave (
    input  ex_waddr, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_temp_i, cnt_i,
    output mem_waddr, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_temp_o, cnt_o
  );
endinterface

// File: rtl/ex_mem_acc.sv
// Multiply-accumulate intermediate fed back to EX; captured only on a bubble edge.
module ex_mem_acc
  import openmips_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             advance,
  input  logic             bubble,
  input  logic [2*DW-1:0]  hilo_temp_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [2*DW-1:0]  hilo_temp_o,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush) begin
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end else if (bubble) begin
      hilo_temp_o <= hilo_temp_i;
      cnt_o       <= cnt_i;
    end else if (advance) begin
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end
  end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with bubble/flush handling and madd/msub feedback.
// Optional EX_MEM_PERF_EN adds a wrapping bubble_cnt performance counter.
module ex_mem
  import openmips_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_ex,
  input  logic        stall_mem,
  input  logic        flush,
  ex_mem_if.slave     bus
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);

  logic advance;
  logic bubble;

  // stall_ex=0 with stall_mem=1 falls through to hold
  assign advance = ~stall_ex & ~stall_mem;
  assign bubble  =  stall_ex & ~stall_mem;

  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush || bubble) begin
      bus.mem_waddr <= AW'(NOPRegAddr);
      bus.mem_wreg  <= WriteDisable;
      bus.mem_wdata <= DW'(ZeroWord);
      bus.mem_whilo <= WriteDisable;
      bus.mem_hi    <= DW'(ZeroWord);
      bus.mem_lo    <= DW'(ZeroWord);
    end else if (advance) begin
      bus.mem_waddr <= bus.ex_waddr;
      bus.mem_wreg  <= bus.ex_wreg;
      bus.mem_wdata <= bus.ex_wdata;
      bus.mem_whilo <= bus.ex_whilo;
      bus.mem_hi    <= bus.ex_hi;
      bus.mem_lo    <= bus.ex_lo;
    end
  end

  ex_mem_acc #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .advance     (advance),
    .bubble      (bubble),
    .hilo_temp_i (bus.hilo_temp_i),
    .cnt_i       (bus.cnt_i),
    .hilo_temp_o (bus.hilo_temp_o),
    .cnt_o       (bus.cnt_o)
  );

`ifdef EX_MEM_PERF_EN
  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush) begin
      bubble_cnt <= '0;
    end else if (bubble) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

  illegal_stall: assert property (@(posedge clk) disable iff (rst == RstEnable)
    !(!stall_ex && stall_mem));

endmodule
